// File: rtl/plab2_proc_alu_arbiter.sv
// Two-requester front end sharing one ALU: round-robin grant, one-entry output register.
// Latency 1 cycle request-to-response; a stalled owner blocks new grants until its result drains.

module plab2_proc_Alu (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [3:0]  fn,
  output logic [31:0] out
);

  logic signed [31:0] sra_res;

  always_comb begin
    sra_res = $signed(in1) >>> in0[4:0];
    out     = '0;
    case (fn)
      4'd0:    out = in0 + in1;
      4'd1:    out = in0 - in1;
      4'd2:    out = in1 << in0[4:0];
      4'd3:    out = in0 | in1;
      4'd4:    out = {31'b0, ($signed(in0) < $signed(in1))};
      4'd5:    out = {31'b0, (in0 < in1)};
      4'd6:    out = in0 & in1;
      4'd7:    out = in0 ^ in1;
      4'd8:    out = ~(in0 | in1);
      4'd9:    out = in1 >> in0[4:0];
      4'd10:   out = sra_res;
      4'd11:   out = in0;
      4'd12:   out = in1;
      default: out = '0;
    endcase
  end

endmodule

module plab2_proc_alu_arbiter #(
  parameter logic p_init_prio = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [3:0]  req0_fn,
  input  logic [31:0] req0_in0,
  input  logic [31:0] req0_in1,

  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic [3:0]  req1_fn,
  input  logic [31:0] req1_in0,
  input  logic [31:0] req1_in1,

  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [31:0] resp0_data,

  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] resp1_data
);

  typedef struct packed {
    logic        vld;
    logic        owner;
    logic [31:0] dat;
  } out_reg_t;

  out_reg_t    out_q;
  logic        prio_q;

  logic        grant_any;
  logic        grant_sel;
  logic        resp_fire;
  logic        can_accept;
  logic        accept;
  logic [3:0]  alu_fn;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [31:0] alu_out;

  always_comb begin
    grant_any  = req0_val | req1_val;
    grant_sel  = (req0_val && req1_val) ? prio_q : req1_val;
    // Only the owner's resp_rdy is looked at; the other port cannot unblock the register.
    resp_fire  = out_q.vld && (out_q.owner ? resp1_rdy : resp0_rdy);
    can_accept = !out_q.vld || resp_fire;
    accept     = reset && grant_any && can_accept;
    req0_rdy   = accept && !grant_sel;
    req1_rdy   = accept && grant_sel;
  end

  always_comb begin
    alu_fn  = grant_sel ? req1_fn  : req0_fn;
    alu_in0 = grant_sel ? req1_in0 : req0_in0;
    alu_in1 = grant_sel ? req1_in1 : req0_in1;
  end

  plab2_proc_Alu u_alu (
    .in0 (alu_in0),
    .in1 (alu_in1),
    .fn  (alu_fn),
    .out (alu_out)
  );

  assign resp0_val  = out_q.vld && !out_q.owner;
  assign resp1_val  = out_q.vld && out_q.owner;
  assign resp0_data = out_q.dat;
  assign resp1_data = out_q.dat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      prio_q <= p_init_prio;
    end else if (accept) begin
      // Reload in the same cycle the previous result drains, so there is no bubble.
      out_q.vld   <= 1'b1;
      out_q.owner <= grant_sel;
      out_q.dat   <= alu_out;
      prio_q      <= !grant_sel;
    end else if (resp_fire) begin
      out_q.vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plab2_proc_alu_arbiter.sv
// Bench for plab2_proc_alu_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.

module tb_plab2_proc_alu_arbiter;

  localparam logic P_INIT = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [3:0]  req0_fn, req1_fn;
  logic [31:0] req0_in0, req0_in1, req1_in0, req1_in1;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] resp0_data, resp1_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plab2_proc_alu_arbiter #(.p_init_prio(P_INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_val   (req0_val),
    .req0_rdy   (req0_rdy),
    .req0_fn    (req0_fn),
    .req0_in0   (req0_in0),
    .req0_in1   (req0_in1),
    .req1_val   (req1_val),
    .req1_rdy   (req1_rdy),
    .req1_fn    (req1_fn),
    .req1_in0   (req1_in0),
    .req1_in1   (req1_in1),
    .resp0_val  (resp0_val),
    .resp0_rdy  (resp0_rdy),
    .resp0_data (resp0_data),
    .resp1_val  (resp1_val),
    .resp1_rdy  (resp1_rdy),
    .resp1_data (resp1_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the function-code table.
  function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (fn)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b << sh;
      4'd3:    return a | b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:    return (a < b) ? 32'd1 : 32'd0;
      4'd6:    return a & b;
      4'd7:    return a ^ b;
      4'd8:    return ~(a | b);
      4'd9:    return b >> sh;
      4'd10:   return 32'($signed(b) >>> sh);
      4'd11:   return a;
      4'd12:   return b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  logic        m_prio = P_INIT;
  logic [31:0] m_data = '0;

  // Model: at most one outstanding result, delivered in grant order.
  always @(negedge clk) begin
    logic busy, own, drain, room, g, e_r0, e_r1, e_v0, e_v1;
    rsp_t r;
    if (!reset) begin
      pend.delete();
      m_prio = P_INIT;
      m_data = '0;
      chk("rst_req0_rdy", {31'b0, req0_rdy}, 32'd0);
      chk("rst_req1_rdy", {31'b0, req1_rdy}, 32'd0);
      chk("rst_resp0_val", {31'b0, resp0_val}, 32'd0);
      chk("rst_resp1_val", {31'b0, resp1_val}, 32'd0);
      chk("rst_resp0_data", resp0_data, 32'd0);
      chk("rst_resp1_data", resp1_data, 32'd0);
    end else begin
      busy  = (pend.size() != 0);
      own   = busy ? pend[0].owner : 1'b0;
      e_v0  = busy && !own;
      e_v1  = busy && own;
      drain = (e_v0 && resp0_rdy) || (e_v1 && resp1_rdy);
      room  = !busy || drain;
      g     = (req0_val && req1_val) ? m_prio : req1_val;
      e_r0  = room && req0_val && !g;
      e_r1  = room && req1_val && g;
      chk("m_req0_rdy", {31'b0, req0_rdy}, {31'b0, e_r0});
      chk("m_req1_rdy", {31'b0, req1_rdy}, {31'b0, e_r1});
      chk("m_resp0_val", {31'b0, resp0_val}, {31'b0, e_v0});
      chk("m_resp1_val", {31'b0, resp1_val}, {31'b0, e_v1});
      chk("m_resp0_data", resp0_data, m_data);
      chk("m_resp1_data", resp1_data, m_data);
      if (drain) void'(pend.pop_front());
      if (e_r0 || e_r1) begin
        r.owner = g;
        r.data  = g ? alu_ref(req1_fn, req1_in0, req1_in1)
                    : alu_ref(req0_fn, req0_in0, req0_in1);
        pend.push_back(r);
        m_data = r.data;
        m_prio = !g;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_val = v; req0_fn = f; req0_in0 = a; req0_in1 = b;
    end else begin
      req1_val = v; req1_fn = f; req1_in0 = a; req1_in1 = b;
    end
  endtask

  logic [31:0] exp_d [4];

  initial begin
    reset = 1'b0;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    exp_d = '{32'd100, 32'd999, 32'd102, 32'd997};

    // Requests during reset must not be accepted.
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    at_neg;
    chk("reset_req0_rdy", {31'b0, req0_rdy}, 32'd0);

    // Single add, accepted on the first edge after release.
    tick;
    reset = 1'b1;
    at_neg;
    chk("add_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    tick;
    req0_val = 1'b0;
    at_neg;
    chk("add_resp0_val", {31'b0, resp0_val}, 32'd1);
    chk("add_resp0_data", resp0_data, 32'd12);
    chk("add_resp1_val", {31'b0, resp1_val}, 32'd0);
    tick;

    // Fresh reset, then both requesters every cycle: alternating grants.
    reset = 1'b0;
    at_neg;
    tick;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 4'd0, 32'(k), 32'd100);
      set_req(1, 1'b1, 4'd1, 32'd1000, 32'(k));
      at_neg;
      chk("rr_req0_rdy", {31'b0, req0_rdy}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_req1_rdy", {31'b0, req1_rdy}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("rr_resp0_val", {31'b0, resp0_val}, ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_resp1_val", {31'b0, resp1_val}, ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_data", resp0_data, exp_d[k-1]);
      end
      tick;
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    at_neg;
    chk("rr_last_resp1_val", {31'b0, resp1_val}, 32'd1);
    chk("rr_last_data", resp1_data, exp_d[3]);
    tick;

    // SRA result held while its owner stalls; both requesters blocked meanwhile.
    set_req(1, 1'b1, 4'd10, 32'd4, 32'h8000_0000);
    resp1_rdy = 1'b0;
    at_neg;
    chk("sra_req1_rdy", {31'b0, req1_rdy}, 32'd1);
    tick;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      at_neg;
      chk("stall_resp1_val", {31'b0, resp1_val}, 32'd1);
      chk("stall_resp1_data", resp1_data, 32'hF800_0000);
      chk("stall_req0_rdy", {31'b0, req0_rdy}, 32'd0);
      chk("stall_req1_rdy", {31'b0, req1_rdy}, 32'd0);
      tick;
    end
    resp1_rdy = 1'b1;
    at_neg;
    chk("drain_resp1_data", resp1_data, 32'hF800_0000);
    chk("drain_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    chk("drain_req1_rdy", {31'b0, req1_rdy}, 32'd0);
    tick;
    req0_val = 1'b0;
    req1_val = 1'b0;
    at_neg;
    chk("drain_resp0_val", {31'b0, resp0_val}, 32'd1);
    chk("drain_resp0_data", resp0_data, 32'd2);
    tick;

    // Copy-in1 then signed SLT back to back.
    set_req(0, 1'b1, 4'd12, 32'd0, 32'hDEAD_BEEF);
    at_neg;
    chk("cp_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    tick;
    set_req(0, 1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1);
    at_neg;
    chk("cp_resp0_data", resp0_data, 32'hDEAD_BEEF);
    chk("slt_req0_rdy", {31'b0, req0_rdy}, 32'd1);
    tick;
    req0_val = 1'b0;
    at_neg;
    chk("slt_resp0_val", {31'b0, resp0_val}, 32'd1);
    chk("slt_resp0_data", resp0_data, 32'd1);
    tick;

    // Undefined fn yields 0; reset mid-flight discards the pending result.
    set_req(1, 1'b1, 4'd14, 32'd5, 32'd7);
    resp1_rdy = 1'b0;
    at_neg;
    chk("fn14_req1_rdy", {31'b0, req1_rdy}, 32'd1);
    tick;
    req1_val = 1'b0;
    at_neg;
    chk("fn14_resp1_val", {31'b0, resp1_val}, 32'd1);
    chk("fn14_resp1_data", resp1_data, 32'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst_now_resp1_val", {31'b0, resp1_val}, 32'd0);
    chk("rst_now_resp0_val", {31'b0, resp0_val}, 32'd0);
    at_neg;
    tick;
    reset = 1'b1;
    resp1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg;
      chk("post_rst_resp1_val", {31'b0, resp1_val}, 32'd0);
      chk("post_rst_resp0_val", {31'b0, resp0_val}, 32'd0);
      tick;
    end

    // Mixed functions with irregular consumer backpressure, checked by the model.
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b1, 4'(k), 32'h8000_0010 ^ 32'(k), 32'h0F0F_00F3 + 32'(k));
      set_req(1, (k % 5) != 2, 4'(15 - k), 32'(k * 3), 32'hFFFF_0000 | 32'(k));
      resp0_rdy = (k % 3) != 0;
      resp1_rdy = (k % 4) != 1;
      tick;
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/plab2_proc_alu_arbiter.md
PLAB2_PROC_ALU_ARBITER -- requirements
Module: plab2_proc_alu_arbiter

Interface
REQ-001 SHALL have parameter p_init_prio, default 0, giving the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports req0_val / req1_val, input, 1 bit each: requester N presents an operation.
REQ-005 SHALL have ports req0_rdy / req1_rdy, output, 1 bit each: arbiter accepts requester N this cycle.
REQ-006 SHALL have ports req0_fn / req1_fn, input, 4 bits each: ALU function code, 0-12 per the team ALU encoding.
REQ-007 SHALL have ports req0_in0, req0_in1, req1_in0, req1_in1, input, 32 bits each: ALU operands.
REQ-008 SHALL have ports resp0_val / resp1_val, output, 1 bit each: result valid for requester N.
REQ-009 SHALL have ports resp0_rdy / resp1_rdy, input, 1 bit each: requester N consumes its result.
REQ-010 SHALL have ports resp0_data / resp1_data, output, 32 bits each: ALU result.

Function
REQ-011 SHALL share one instance of the team ALU (plab2_proc_Alu) between the two requesters; no second ALU.
REQ-012 SHALL fire a request transfer only when val and rdy are both high in the same cycle; likewise for responses.
REQ-013 SHALL hold one output register: valid bit, 32-bit result, 1-bit owner tag.
REQ-014 SHALL define can_accept = !out_valid OR (resp_val of owner AND resp_rdy of owner) in the same cycle.
REQ-015 SHALL assert at most one req_rdy per cycle; req_rdy is high only for the granted requester and only when can_accept.
REQ-016 SHALL grant combinationally: only one val -> that requester; both val -> requester holding priority.
REQ-017 SHALL toggle priority to the non-granted requester after every accepted request; no change on cycles without an accept.
REQ-018 SHALL capture the ALU output for the granted operands into the output register on accept, giving a fixed latency of 1 cycle from request fire to resp_val.
REQ-019 SHALL drive respN_val = out_valid AND (owner == N); the other port's resp_val SHALL stay 0.
REQ-020 SHALL drive both resp0_data and resp1_data from the output register regardless of owner.
REQ-021 SHALL hold result and owner stable while resp_val is high and resp_rdy is low; head-of-line blocking is accepted behaviour.
REQ-022 SHALL, on response fire with no new accept, clear out_valid; with a simultaneous accept, reload without a bubble, giving 1 operation/cycle sustained throughput.
REQ-023 SHALL produce result 32'd0 for fn codes 13-15 and SHALL NOT flag an error.
REQ-024 SHALL make req_rdy independent of req_val of the same port only through the grant logic; there is no combinational path from resp_rdy of the non-owner to any output.

Reset
REQ-025 SHALL, while reset is 0, force out_valid=0, owner=0, result=0, and priority=p_init_prio; all req_rdy and resp_val SHALL read 0.
REQ-026 SHALL discard any in-flight result when reset asserts mid-operation; no response is delivered for it after release.
REQ-027 SHALL permit the first accept in the first rising edge after reset deasserts.

Verification
REQ-028 SHALL pass: reset, then req0 only: fn=0, in0=5, in1=7 -> req0_rdy=1; next cycle resp0_val=1, resp0_data=12, resp1_val=0.
REQ-029 SHALL pass: both val every cycle, resp_rdy both 1, p_init_prio=0 -> grants 0,1,0,1; results returned in the same order with 1-cycle latency.
REQ-030 SHALL pass: req1 fn=10 (SRA), in0=4, in1=0x80000000, resp1_rdy=0 for 3 cycles -> resp1_data=0xF8000000 held stable; req0_rdy=req1_rdy=0 until drain.
REQ-031 SHALL pass: fn=12 (copy in1), in1=0xDEADBEEF, back-to-back with fn=4 (SLT), in0=-1, in1=1 -> results 0xDEADBEEF, then 1, no bubble.
REQ-032 SHALL pass: fn=14 -> result 0; reset pulsed while out_valid=1 -> resp_val drops immediately, and no stale response appears after release.
